// File: rtl/frame_buffer_ctrl_pkg.sv
// Shared types and defaults for the camera frame buffer sequencer.
// The FSM state encoding lives here so the controller and any checker agree on it.
package frame_buffer_ctrl_pkg;

    localparam int FB_ADDR_W      = 16;
    localparam int FB_DATA_W      = 16;
    localparam int FB_FRAME_WORDS = 19200;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ARMED    = 3'd1,
        ST_CAPTURE  = 3'd2,
        ST_RD_ISSUE = 3'd3,
        ST_RD_WAIT  = 3'd4,
        ST_RD_HOLD  = 3'd5
    } fb_state_e;

endpackage

// File: rtl/frame_buffer_ctrl_if.sv
// Bundle of the pixel capture, replay stream, status and bigram port signals.
// The controller connects through the slave modport; its environment uses master.
interface frame_buffer_ctrl_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              cap_start;
    logic              pix_vsync;
    logic              pix_valid;
    logic [DATA_W-1:0] pix_data;
    logic              rd_start;
    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic              busy;
    logic              frame_done;
    logic [ADDR_W:0]   frame_len;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic              ram_wren;
    logic [DATA_W-1:0] ram_dout;

    modport slave (
        input  cap_start, pix_vsync, pix_valid, pix_data, rd_start, rd_ready, ram_dout,
        output rd_valid, rd_data, busy, frame_done, frame_len, ram_addr, ram_din, ram_wren
    );

    modport master (
        output cap_start, pix_vsync, pix_valid, pix_data, rd_start, rd_ready, ram_dout,
        input  rd_valid, rd_data, busy, frame_done, frame_len, ram_addr, ram_din, ram_wren
    );
endinterface

// File: rtl/frame_buffer_ctrl.sv
// Captures one camera frame into the bigram store and replays it over a valid/ready stream.
// Sole master of the RAM port; every output comes straight from a register.
module frame_buffer_ctrl
    import frame_buffer_ctrl_pkg::*;
#(
    parameter int ADDR_W      = FB_ADDR_W,
    parameter int DATA_W      = FB_DATA_W,
    parameter int FRAME_WORDS = FB_FRAME_WORDS
) (
    input  logic                  clk_ram,
    input  logic                  rst_n,
    frame_buffer_ctrl_if.slave    bus
);

    localparam logic [ADDR_W:0] FW_LEN  = (ADDR_W + 1)'(FRAME_WORDS);
    localparam logic [ADDR_W:0] FW_LAST = FW_LEN - {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

    fb_state_e         state_q, state_d;
    logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_din_q, ram_din_d;
    logic              ram_wren_q, ram_wren_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              busy_q, busy_d;
    logic              frame_done_q, frame_done_d;
    logic [ADDR_W:0]   frame_len_q, frame_len_d;
    logic [ADDR_W:0]   wr_ptr_inc_s;
    logic [ADDR_W:0]   rd_ptr_inc_s;
    logic              wr_last_s;

    assign wr_ptr_inc_s = wr_ptr_q + PTR_ONE;
    assign rd_ptr_inc_s = rd_ptr_q + PTR_ONE;
    assign wr_last_s    = (wr_ptr_q == FW_LAST);

    // Next-state and next-output logic for capture and replay sequencing.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        ram_addr_d   = ram_addr_q;
        ram_din_d    = ram_din_q;
        ram_wren_d   = 1'b0;
        rd_data_d    = rd_data_q;
        rd_valid_d   = rd_valid_q;
        frame_done_d = frame_done_q;
        frame_len_d  = frame_len_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.cap_start) begin
                    state_d      = ST_ARMED;
                    frame_done_d = 1'b0;
                    frame_len_d  = '0;
                    wr_ptr_d     = '0;
                end else if (bus.rd_start && frame_done_q && (frame_len_q != '0)) begin
                    state_d    = ST_RD_ISSUE;
                    ram_addr_d = '0;
                    rd_ptr_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_ARMED: begin
                if (bus.pix_vsync) begin
                    state_d = ST_CAPTURE;
                    if (bus.pix_valid) begin
                        ram_addr_d = wr_ptr_q[ADDR_W-1:0];
                        ram_din_d  = bus.pix_data;
                        ram_wren_d = 1'b1;
                        wr_ptr_d   = wr_ptr_inc_s;
                        if (wr_last_s) begin
                            state_d      = ST_IDLE;
                            frame_len_d  = FW_LEN;
                            frame_done_d = 1'b1;
                        end else begin
                            state_d = ST_CAPTURE;
                        end
                    end else begin
                        wr_ptr_d = wr_ptr_q;
                    end
                end else begin
                    state_d = ST_ARMED;
                end
            end

            // The last word of a full frame is kept even if vsync lands on it.
            ST_CAPTURE: begin
                if (bus.pix_valid && (wr_last_s || !bus.pix_vsync)) begin
                    ram_addr_d = wr_ptr_q[ADDR_W-1:0];
                    ram_din_d  = bus.pix_data;
                    ram_wren_d = 1'b1;
                    wr_ptr_d   = wr_ptr_inc_s;
                    if (wr_last_s) begin
                        state_d      = ST_IDLE;
                        frame_len_d  = FW_LEN;
                        frame_done_d = 1'b1;
                    end else begin
                        state_d = ST_CAPTURE;
                    end
                end else if (bus.pix_vsync) begin
                    state_d      = ST_IDLE;
                    frame_len_d  = wr_ptr_q;
                    frame_done_d = 1'b1;
                end else begin
                    state_d = ST_CAPTURE;
                end
            end

            ST_RD_ISSUE: begin
                state_d = ST_RD_WAIT;
            end

            ST_RD_WAIT: begin
                rd_data_d  = bus.ram_dout;
                rd_valid_d = 1'b1;
                state_d    = ST_RD_HOLD;
            end

            ST_RD_HOLD: begin
                if (bus.rd_ready) begin
                    rd_valid_d = 1'b0;
                    if (rd_ptr_q == (frame_len_q - PTR_ONE)) begin
                        state_d = ST_IDLE;
                    end else begin
                        rd_ptr_d   = rd_ptr_inc_s;
                        ram_addr_d = rd_ptr_inc_s[ADDR_W-1:0];
                        state_d    = ST_RD_ISSUE;
                    end
                end else begin
                    state_d = ST_RD_HOLD;
                end
            end

            default: begin
                state_d    = ST_IDLE;
                rd_valid_d = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset drops ram_wren and aborts any operation at once.
    always_ff @(posedge clk_ram or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            ram_addr_q   <= '0;
            ram_din_q    <= '0;
            ram_wren_q   <= 1'b0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            frame_len_q  <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            ram_addr_q   <= ram_addr_d;
            ram_din_q    <= ram_din_d;
            ram_wren_q   <= ram_wren_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            frame_len_q  <= frame_len_d;
        end
    end

    assign bus.ram_addr   = ram_addr_q;
    assign bus.ram_din    = ram_din_q;
    assign bus.ram_wren   = ram_wren_q;
    assign bus.rd_data    = rd_data_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;
    assign bus.frame_len  = frame_len_q;

endmodule
